// File: rtl/laser_feeder.sv
// laser_feeder
//   Buffers host points into two 40-entry ping-pong banks and streams one
//   full frame at a time to a circle-cover core. It then waits for the
//   core's DONE and latches the resulting circle centres.
//
//   Optional feature: define FEEDER_TIMEOUT_EN to add a 12-bit WAIT_DONE
//   watchdog and the sticky TIMEOUT output.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   IN_VALID/IN_READY       ingress handshake for one point
//   IN_X, IN_Y              ingress point coordinates (4 bits each)
//   CORE_RST                active-high reset to the core (high in HOLD)
//   X, Y                    streamed point (0 outside STREAM)
//   DONE                    core result valid (sampled only in WAIT_DONE)
//   C1X, C1Y, C2X, C2Y      core circle centres
//   RES_VALID               one-cycle pulse when a result is latched
//   RES_C1X..RES_C2Y        latched centres
//   FRAME_CNT               completed frames, mod 256
//   TIMEOUT                 sticky watchdog flag (FEEDER_TIMEOUT_EN only)
module laser_feeder (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [3:0] IN_X,
   input  logic [3:0] IN_Y,
   output logic       CORE_RST,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       DONE,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   output logic       RES_VALID,
   output logic [3:0] RES_C1X,
   output logic [3:0] RES_C1Y,
   output logic [3:0] RES_C2X,
   output logic [3:0] RES_C2Y,
   output logic [7:0] FRAME_CNT
`ifdef FEEDER_TIMEOUT_EN
   ,
   output logic       TIMEOUT
`endif
);

   localparam logic [5:0] LAST_IDX = 6'd39;

   typedef enum logic [1:0] {
      HOLD,
      STREAM,
      WAIT_DONE
   } state_t;

   state_t     state;
   logic       wr_bank;
   logic       rd_bank;
   logic [5:0] wr_idx;
   logic [5:0] rd_idx;
   logic [1:0] bank_full;
   logic       accept;
   logic [7:0] rd_pt;

   // Point storage: {x, y} per entry, contents need no reset.
   logic [7:0] bank_mem [0:1][0:39];

`ifdef FEEDER_TIMEOUT_EN
   logic [11:0] wdog;
`endif

   always_comb begin
      IN_READY = ~bank_full[wr_bank];
      accept   = IN_VALID & IN_READY;
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         bank_mem[wr_bank][wr_idx] <= {IN_X, IN_Y};
      end
   end

   always_comb begin
      rd_pt = bank_mem[rd_bank][rd_idx];
      X     = '0;
      Y     = '0;
      if (state == STREAM) begin
         X = rd_pt[7:4];
         Y = rd_pt[3:0];
      end
   end

   // Ingress and FSM share one block because both touch bank_full. A bank
   // being streamed is always full, so ingress never targets it: the set
   // (wr_bank) and the clear (rd_bank) never hit the same bit in one cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= HOLD;
         CORE_RST  <= 1'b1;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         bank_full <= '0;
         RES_VALID <= 1'b0;
         RES_C1X   <= '0;
         RES_C1Y   <= '0;
         RES_C2X   <= '0;
         RES_C2Y   <= '0;
         FRAME_CNT <= '0;
`ifdef FEEDER_TIMEOUT_EN
         wdog      <= '0;
         TIMEOUT   <= 1'b0;
`endif
      end else begin
         RES_VALID <= 1'b0;

         if (accept) begin
            if (wr_idx == LAST_IDX) begin
               bank_full[wr_bank] <= 1'b1;
               wr_idx             <= '0;
               wr_bank            <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + 6'd1;
            end
         end

         case (state)
            HOLD: begin
               if (bank_full[rd_bank]) begin
                  state    <= STREAM;
                  CORE_RST <= 1'b0;
               end
            end

            STREAM: begin
               if (rd_idx == LAST_IDX) begin
                  state              <= WAIT_DONE;
                  bank_full[rd_bank] <= 1'b0;
                  rd_bank            <= ~rd_bank;
                  rd_idx             <= '0;
`ifdef FEEDER_TIMEOUT_EN
                  wdog               <= '0;
`endif
               end else begin
                  rd_idx <= rd_idx + 6'd1;
               end
            end

            WAIT_DONE: begin
               if (DONE) begin
                  state     <= HOLD;
                  CORE_RST  <= 1'b1;
                  RES_VALID <= 1'b1;
                  RES_C1X   <= C1X;
                  RES_C1Y   <= C1Y;
                  RES_C2X   <= C2X;
                  RES_C2Y   <= C2Y;
                  FRAME_CNT <= FRAME_CNT + 8'd1;
               end
`ifdef FEEDER_TIMEOUT_EN
               // wdog holds the number of WAIT_DONE cycles already spent;
               // the 4095th cycle without DONE drops the frame.
               else if (wdog == 12'd4094) begin
                  state    <= HOLD;
                  CORE_RST <= 1'b1;
                  TIMEOUT  <= 1'b1;
               end else begin
                  wdog <= wdog + 12'd1;
               end
`endif
            end

            default: begin
               state    <= HOLD;
               CORE_RST <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_laser_feeder.sv
// tb_laser_feeder
//   Randomized and directed stimulus for laser_feeder, checked every cycle
//   against a frame-level reference model. The model keeps complete frames
//   as a flat byte queue (40 bytes per frame) and a partial-frame queue.
//   Define FEEDER_TIMEOUT_EN to also exercise the watchdog.
module tb_laser_feeder;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [3:0] IN_X = '0;
   logic [3:0] IN_Y = '0;
   logic       CORE_RST;
   logic [3:0] X;
   logic [3:0] Y;
   logic       DONE = 1'b0;
   logic [3:0] C1X = '0;
   logic [3:0] C1Y = '0;
   logic [3:0] C2X = '0;
   logic [3:0] C2Y = '0;
   logic       RES_VALID;
   logic [3:0] RES_C1X;
   logic [3:0] RES_C1Y;
   logic [3:0] RES_C2X;
   logic [3:0] RES_C2Y;
   logic [7:0] FRAME_CNT;
`ifdef FEEDER_TIMEOUT_EN
   logic       TIMEOUT;
`endif

   always #5 CLK = ~CLK;

   laser_feeder dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_X      (IN_X),
      .IN_Y      (IN_Y),
      .CORE_RST  (CORE_RST),
      .X         (X),
      .Y         (Y),
      .DONE      (DONE),
      .C1X       (C1X),
      .C1Y       (C1Y),
      .C2X       (C2X),
      .C2Y       (C2Y),
      .RES_VALID (RES_VALID),
      .RES_C1X   (RES_C1X),
      .RES_C1Y   (RES_C1Y),
      .RES_C2X   (RES_C2X),
      .RES_C2Y   (RES_C2Y),
      .FRAME_CNT (FRAME_CNT)
`ifdef FEEDER_TIMEOUT_EN
      ,
      .TIMEOUT   (TIMEOUT)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
   endtask

   // Reference model: what the block should be doing, in frame terms.
   typedef enum int {M_HOLD, M_STREAM, M_WAIT} mph_t;

   logic [7:0] m_buf[$];    // complete, not yet streamed-out frames
   logic [7:0] m_part[$];   // points of the frame being collected
   mph_t       m_phase;
   int         m_pos;
   int         m_wait;
   int         m_frames_done;
   logic [7:0] m_cnt;
   logic       m_rv;
   logic [3:0] m_r [4];
   logic       m_to;

   task automatic model_reset();
      m_buf.delete();
      m_part.delete();
      m_phase = M_HOLD;
      m_pos   = 0;
      m_wait  = 0;
      m_cnt   = '0;
      m_rv    = 1'b0;
      m_to    = 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
   endtask

   task automatic compare_all();
      logic [7:0] e;
      e = (m_phase == M_STREAM) ? m_buf[m_pos] : 8'h00;
      chk("in_ready",  IN_READY,  m_buf.size() < 80);
      chk("core_rst",  CORE_RST,  m_phase == M_HOLD);
      chk("x",         X,         e[7:4]);
      chk("y",         Y,         e[3:0]);
      chk("res_valid", RES_VALID, m_rv);
      chk("res_c1x",   RES_C1X,   m_r[0]);
      chk("res_c1y",   RES_C1Y,   m_r[1]);
      chk("res_c2x",   RES_C2X,   m_r[2]);
      chk("res_c2y",   RES_C2Y,   m_r[3]);
      chk("frame_cnt", FRAME_CNT, m_cnt);
`ifdef FEEDER_TIMEOUT_EN
      chk("timeout",   TIMEOUT,   m_to);
`endif
   endtask

   // One clock: advance the model with the currently driven inputs, let the
   // edge happen, then compare.
   task automatic step();
      logic acc;
      logic [7:0] pt;
      acc  = IN_VALID && (m_buf.size() < 80);
      pt   = {IN_X, IN_Y};
      m_rv = 1'b0;
      case (m_phase)
         M_HOLD: begin
            if (m_buf.size() >= 40) begin
               m_phase = M_STREAM;
               m_pos   = 0;
            end
         end
         M_STREAM: begin
            if (m_pos == 39) begin
               for (int i = 0; i < 40; i++) void'(m_buf.pop_front());
               m_phase = M_WAIT;
               m_wait  = 0;
            end else begin
               m_pos++;
            end
         end
         M_WAIT: begin
            if (DONE) begin
               m_rv    = 1'b1;
               m_r[0]  = C1X;
               m_r[1]  = C1Y;
               m_r[2]  = C2X;
               m_r[3]  = C2Y;
               m_cnt   = m_cnt + 8'd1;
               m_frames_done++;
               m_phase = M_HOLD;
            end
`ifdef FEEDER_TIMEOUT_EN
            else begin
               m_wait++;
               if (m_wait == 4095) begin
                  m_to    = 1'b1;
                  m_phase = M_HOLD;
               end
            end
`endif
         end
         default: m_phase = M_HOLD;
      endcase
      if (acc) begin
         m_part.push_back(pt);
         if (m_part.size() == 40) begin
            foreach (m_part[i]) m_buf.push_back(m_part[i]);
            m_part.delete();
         end
      end
      @(posedge CLK);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      #2;
      RST_N    = 1'b0;
      IN_VALID = 1'b0;
      DONE     = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_core_rst", CORE_RST, 1);
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_frame_cnt", FRAME_CNT, 0);
      @(posedge CLK);
      #1;
      compare_all();
      RST_N = 1'b1;
   endtask

   task automatic step_until(input mph_t ph, input string tag);
      int n;
      n = 0;
      while (m_phase != ph && n < 300) begin
         step();
         n++;
      end
      if (m_phase != ph) chk(tag, m_phase, ph);
   endtask

   task automatic push_random(input int n);
      IN_VALID = 1'b1;
      for (int i = 0; i < n; i++) begin
         IN_X = 4'($urandom_range(0, 15));
         IN_Y = 4'($urandom_range(0, 15));
         step();
      end
      IN_VALID = 1'b0;
   endtask

   task automatic finish_frame();
      step_until(M_WAIT, "bound_wait_done");
      C1X  = 4'($urandom_range(0, 15));
      C1Y  = 4'($urandom_range(0, 15));
      C2X  = 4'($urandom_range(0, 15));
      C2Y  = 4'($urandom_range(0, 15));
      DONE = 1'b1;
      step();
      DONE = 1'b0;
      step();
   endtask

   initial begin
      int acc_n;
      int cyc;
      logic [7:0] cnt_before;
      m_frames_done = 0;
      model_reset();

      // Reset state
      apply_reset();

      // 40 points k = (k mod 16, k/3), streamed back in order
      IN_VALID = 1'b1;
      for (int k = 0; k < 40; k++) begin
         IN_X = 4'(k % 16);
         IN_Y = 4'(k / 3);
         chk("seq_ready", IN_READY, 1);
         step();
      end
      IN_VALID = 1'b0;
      chk("seq_core_rst_hold", CORE_RST, 1);
      step();
      chk("seq_core_rst_fall", CORE_RST, 0);
      for (int k = 0; k < 40; k++) begin
         chk("seq_x", X, k % 16);
         chk("seq_y", Y, k / 3);
         step();
      end
      chk("seq_wait_x", X, 0);
      chk("seq_wait_core_rst", CORE_RST, 0);

      // Result capture
      repeat (3) step();
      C1X = 4'd3; C1Y = 4'd5; C2X = 4'd9; C2Y = 4'd12;
      DONE = 1'b1;
      step();
      DONE = 1'b0;
      chk("res_pulse", RES_VALID, 1);
      chk("res_c1x_val", RES_C1X, 3);
      chk("res_c1y_val", RES_C1Y, 5);
      chk("res_c2x_val", RES_C2X, 9);
      chk("res_c2y_val", RES_C2Y, 12);
      chk("res_cnt", FRAME_CNT, 1);
      chk("res_core_rst", CORE_RST, 1);
      step();
      chk("res_pulse_end", RES_VALID, 0);

      // 80 points back to back: both banks fill, one stall cycle
      acc_n    = 0;
      IN_VALID = 1'b1;
      for (int i = 0; i < 80; i++) begin
         IN_X = 4'($urandom_range(0, 15));
         IN_Y = 4'($urandom_range(0, 15));
         if (IN_READY) acc_n++;
         step();
      end
      chk("b2b_accepts", acc_n, 80);
      chk("b2b_ready_low", IN_READY, 0);
      step();
      IN_VALID = 1'b0;
      chk("b2b_ready_back", IN_READY, 1);
      finish_frame();

      // DONE during STREAM is ignored
      step_until(M_STREAM, "bound_stream");
      repeat (5) step();
      DONE = 1'b1;
      step();
      DONE = 1'b0;
      chk("stream_done_ignored", RES_VALID, 0);
      chk("stream_done_cnt", FRAME_CNT, 2);
      finish_frame();

      // Reset with 1.5 frames buffered at read index 20
      push_random(60);
      step();
      chk("midrst_streaming", CORE_RST, 0);
      apply_reset();
      push_random(39);
      repeat (5) begin
         step();
         chk("midrst_no_stream", CORE_RST, 1);
      end
      push_random(1);
      chk("midrst_hold", CORE_RST, 1);
      step();
      chk("midrst_restart", CORE_RST, 0);
      finish_frame();

`ifdef FEEDER_TIMEOUT_EN
      // Watchdog: frame dropped, next buffered frame streams
      push_random(80);
      step_until(M_WAIT, "bound_wd_wait");
      cnt_before = FRAME_CNT;
      repeat (4094) step();
      chk("wd_not_yet", TIMEOUT, 0);
      step();
      chk("wd_timeout", TIMEOUT, 1);
      chk("wd_core_rst", CORE_RST, 1);
      chk("wd_cnt_same", FRAME_CNT, cnt_before);
      step();
      chk("wd_next_stream", CORE_RST, 0);
      finish_frame();
`endif

      // Random traffic, long enough to wrap FRAME_CNT
      cyc = 0;
      while (m_frames_done < 270 && cyc < 40000) begin
         IN_VALID = ($urandom_range(0, 9) < 8);
         IN_X     = 4'($urandom_range(0, 15));
         IN_Y     = 4'($urandom_range(0, 15));
         DONE     = ($urandom_range(0, 5) == 0);
         C1X      = 4'($urandom_range(0, 15));
         C1Y      = 4'($urandom_range(0, 15));
         C2X      = 4'($urandom_range(0, 15));
         C2Y      = 4'($urandom_range(0, 15));
         step();
         cyc++;
      end
      IN_VALID = 1'b0;
      DONE     = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/laser_feeder.md
LASER_FEEDER -- requirements
Module: laser_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows: CLK  in  1  rising-edge clock; RST_N  in  1  asynchronous active-low reset.
REQ-002 Host ingress ports SHALL be: IN_VALID  in  1  point valid; IN_READY  out  1  point accepted when IN_VALID&IN_READY; IN_X  in  4  point x; IN_Y  in  4  point y.
REQ-003 Core-side ports SHALL be: CORE_RST  out  1  active-high reset to circle-cover core; X  out  4  streamed x; Y  out  4  streamed y; DONE  in  1  core result valid; C1X/C1Y/C2X/C2Y  in  4 each  core circle centres.
REQ-004 Result ports SHALL be: RES_VALID  out  1  one-cycle result pulse; RES_C1X/RES_C1Y/RES_C2X/RES_C2Y  out  4 each  latched centres; FRAME_CNT  out  8  completed frames; TIMEOUT  out  1  sticky watchdog flag (only with FEEDER_TIMEOUT_EN).

Function
REQ-005 A frame SHALL be exactly 40 points; storage SHALL be two banks of 40x8 bits (ping-pong).
REQ-006 Ingress SHALL write IN_{X,Y} to wr_bank[wr_idx] on each handshake; wr_idx SHALL count 0..39, and on the handshake at 39 the bank SHALL be marked full, wr_idx SHALL wrap to 0, and wr_bank SHALL toggle.
REQ-007 IN_READY SHALL be 1 iff the current wr_bank is not full (combinational from registered state); with both banks full, IN_READY SHALL be 0.
REQ-008 The FSM SHALL have states HOLD, STREAM, WAIT_DONE.
REQ-009 HOLD: CORE_RST=1; the FSM SHALL go to STREAM when rd_bank is full, otherwise stay in HOLD.
REQ-010 STREAM: CORE_RST=0; X/Y SHALL equal rd_bank[rd_idx] combinationally; rd_idx SHALL run 0..39, one point per cycle, with no stalls.
REQ-011 Point 0 SHALL appear in the first cycle after CORE_RST falls.
REQ-012 At rd_idx==39, the FSM SHALL go to WAIT_DONE, clear rd_bank full, toggle rd_bank, and reset rd_idx to 0.
REQ-013 A bank freed and refilled in the same cycle SHALL resolve as: the clear occurs first, then ingress may write from the next cycle.
REQ-014 WAIT_DONE: CORE_RST=0; X=Y=0; on DONE==1 the block SHALL latch C1X..C2Y into RES_*, pulse RES_VALID for one cycle, increment FRAME_CNT (mod 256), and go to HOLD.
REQ-015 HOLD SHALL last at least one cycle after every frame.
REQ-016 Outside STREAM, X and Y SHALL be 0.
REQ-017 DONE SHALL be ignored outside WAIT_DONE.
REQ-018 Ingress SHALL run concurrently with streaming, so the next frame may load while the current one streams.
REQ-019 Frame-to-frame latency with both banks preloaded SHALL be 40 STREAM cycles + core compute + 1 HOLD cycle.

Reset
REQ-020 On RST_N=0, asynchronously: state=HOLD, CORE_RST=1, X=Y=0, IN_READY=1 after release, wr/rd bank=0, wr_idx=rd_idx=0, both banks not full, RES_VALID=0, RES_*=0, FRAME_CNT=0, TIMEOUT=0.
REQ-021 Bank contents SHALL NOT require reset.
REQ-022 Reset mid-frame SHALL discard all partial and buffered frames.

Configuration
REQ-023 With macro FEEDER_TIMEOUT_EN defined, a 12-bit watchdog SHALL count WAIT_DONE cycles; on reaching 4095 without DONE, the block SHALL set sticky TIMEOUT=1, go to HOLD without RES_VALID or FRAME_CNT change, and drop the frame.
REQ-024 TIMEOUT SHALL clear only on reset.
REQ-025 Without FEEDER_TIMEOUT_EN, there SHALL be no watchdog, TIMEOUT SHALL be absent, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-026 Bench SHALL cover reset, then 40 handshakes with point k=(k mod 16, k/3) -> IN_READY stays 1, CORE_RST falls the cycle after the 40th accept+1, X/Y show points 0..39 on 40 consecutive cycles.
REQ-027 Bench SHALL cover 80 points pushed back-to-back with IN_VALID=1 -> first 80 accepted, then IN_READY=0 until first stream ends, then IN_READY=1 exactly one cycle after rd_idx==39.
REQ-028 Bench SHALL cover DONE=1 with C1=(3,5), C2=(9,12) in WAIT_DONE -> RES_VALID 1 cycle, RES_C1X=3, RES_C1Y=5, RES_C2X=9, RES_C2Y=12, FRAME_CNT=1, CORE_RST=1 next cycle.
REQ-029 Bench SHALL cover DONE pulsed during STREAM -> ignored: no RES_VALID, FRAME_CNT unchanged.
REQ-030 Bench SHALL cover RST_N asserted at rd_idx==20 with 1.5 frames buffered -> all state cleared, CORE_RST=1, no stream until 40 new points accepted.
REQ-031 Bench SHALL cover, with FEEDER_TIMEOUT_EN, DONE held 0 in WAIT_DONE -> TIMEOUT=1 after 4095 cycles, state HOLD, FRAME_CNT unchanged, next buffered frame streams.
